// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: depth derivation and threshold sanity check.
// Reused by every FIFO variant so the parameter rules stay in one place.
package fifo_pkg;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic bit fifo_th_ok(input int aempty_th, input int afull_th, input int depth);
    return (aempty_th >= 0) && (aempty_th < afull_th) && (afull_th <= depth);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: increments on i_inc, cleared by i_clr or rst.
// Clear wins over increment so a flush cycle never advances the pointer.
module fifo_ptr #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with thresholds, sticky errors, flush and
// selectable registered / first-word-fall-through read data.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int AFULL_TH  = fifo_depth(ADDR_W) - 4,
  parameter int AEMPTY_TH = 4,
  parameter bit FWFT      = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = fifo_depth(ADDR_W);
  localparam logic [ADDR_W:0] AF_TH = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_TH = AEMPTY_TH[ADDR_W:0];

  if (!fifo_th_ok(AEMPTY_TH, AFULL_TH, DEPTH)) begin : g_bad_th
    $error("param_fifo: thresholds must satisfy 0 <= AEMPTY_TH < AFULL_TH <= DEPTH");
  end

  logic [ADDR_W:0]   w_wr_ptr;
  logic [ADDR_W:0]   w_rd_ptr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_overflow;
  logic              r_underflow;

  assign w_wr_addr = w_wr_ptr[ADDR_W-1:0];
  assign w_rd_addr = w_rd_ptr[ADDR_W-1:0];
  assign w_empty   = (w_wr_ptr == w_rd_ptr);
  assign w_full    = (w_wr_addr == w_rd_addr) && (w_wr_ptr[ADDR_W] != w_rd_ptr[ADDR_W]);
  assign w_wr_acc  = wr_en & ~w_full;
  assign w_rd_acc  = rd_en & ~w_empty;

  fifo_ptr #(.W(ADDR_W + 1)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (flush),
    .i_inc (w_wr_acc),
    .o_ptr (w_wr_ptr)
  );

  fifo_ptr #(.W(ADDR_W + 1)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (flush),
    .i_inc (w_rd_acc),
    .o_ptr (w_rd_ptr)
  );

  // Storage is deliberately unreset; contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !flush) begin
      r_mem[w_wr_addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  if (FWFT) begin : g_fwft
    assign rdata = r_mem[w_rd_addr];
  end else begin : g_reg_rd
    logic [DATA_W-1:0] r_rdata;

    // Flush leaves the last popped word in place.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rdata <= '0;
      end else if (w_rd_acc && !flush) begin
        r_rdata <= r_mem[w_rd_addr];
      end
    end

    assign rdata = r_rdata;
  end

  // Pointer difference is the occupancy; wrap bit makes it exact at DEPTH.
  assign count        = w_wr_ptr - w_rd_ptr;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench: hand vectors, directed corner sequences and random
// traffic against a queue-based model, for both registered and FWFT builds.
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush, wr_en, rd_en;
  logic [7:0] wdata;

  logic [7:0] rdata0, rdataf;
  logic       full0, empty0, af0, ae0, ov0, un0;
  logic       fullf, emptyf, aff, aef, ovf, unf;
  logic [5:0] count0, countf;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       m_ov, m_un;
  logic [7:0] m_rdata;

  always #5 clk = ~clk;

  param_fifo #(.DATA_W(8), .ADDR_W(5), .AFULL_TH(28), .AEMPTY_TH(4), .FWFT(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ov0), .underflow(un0)
  );

  param_fifo #(.DATA_W(8), .ADDR_W(5), .AFULL_TH(28), .AEMPTY_TH(4), .FWFT(1'b1)) dut_f (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdataf), .full(fullf), .empty(emptyf), .almost_full(aff), .almost_empty(aef),
    .count(countf), .overflow(ovf), .underflow(unf)
  );

  typedef struct {
    logic       f, w;
    logic [7:0] d;
    logic       r;
    logic [5:0] cnt;
    logic       ful, emp, ov, un;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    m_rdata = 8'h00;
  endtask

  task automatic model_update(input logic f, input logic w, input logic [7:0] d, input logic r);
    int n;
    n = q.size();
    if (f) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      if (w && n == 32) m_ov = 1'b1;
      if (r && n == 0)  m_un = 1'b1;
      if (r && n != 0)  m_rdata = q.pop_front();
      if (w && n != 32) q.push_back(d);
    end
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("count", 32'(count0), 32'(n));
    chk("full", 32'(full0), 32'(n == 32));
    chk("empty", 32'(empty0), 32'(n == 0));
    chk("almost_full", 32'(af0), 32'(n >= 28));
    chk("almost_empty", 32'(ae0), 32'(n <= 4));
    chk("overflow", 32'(ov0), 32'(m_ov));
    chk("underflow", 32'(un0), 32'(m_un));
    chk("rdata", 32'(rdata0), 32'(m_rdata));
    chk("fwft_flags", {countf, fullf, emptyf, aff, aef, ovf, unf},
        {6'(n), n == 32, n == 0, n >= 28, n <= 4, m_ov, m_un});
    if (n != 0) chk("fwft_rdata", 32'(rdataf), 32'(q[0]));
  endtask

  // Drive one cycle; the model advances on the same edge as the DUT.
  task automatic step(input logic f, input logic w, input logic [7:0] d, input logic r);
    flush = f; wr_en = w; wdata = d; rd_en = r;
    @(posedge clk);
    model_update(f, w, d, r);
    #1;
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, base + 8'(i), 1'b0);
      check_model();
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check_model();
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 8'h11, 1'b0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 8'h22, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[3] = '{1'b0, 1'b1, 8'h33, 1'b1, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33};
    tbl[6] = '{1'b0, 1'b1, 8'h44, 1'b1, 6'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33};
    tbl[7] = '{1'b1, 1'b1, 8'h55, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33};

    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_vals", {rdata0, full0, empty0, af0, ae0, count0, ov0, un0},
        {8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0});

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].f, tbl[i].w, tbl[i].d, tbl[i].r);
      chk($sformatf("vec%0d", i), {count0, full0, empty0, ov0, un0, rdata0},
          {tbl[i].cnt, tbl[i].ful, tbl[i].emp, tbl[i].ov, tbl[i].un, tbl[i].rd});
    end

    // Fill to full, watching almost_full and full edges, then drain in order.
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0);
      check_model();
      if (i == 26) chk("af_at_27", 32'(af0), 32'd0);
      if (i == 27) chk("af_at_28", 32'(af0), 32'd1);
      if (i == 30) chk("full_at_31", 32'(full0), 32'd0);
      if (i == 31) chk("full_at_32", {full0, count0}, {1'b1, 6'd32});
    end
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("drain_order", 32'(rdata0), 32'(i));
      check_model();
    end
    chk("empty_after_drain", 32'(empty0), 32'd1);

    // Overflow on full, underflow on empty with rdata held.
    fill(32, 8'h80);
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    chk("ovf_set", {ov0, count0}, {1'b1, 6'd32});
    drain(32);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("unf_set_rdata_held", {un0, rdata0}, {1'b1, 8'h9F});
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check_model();

    // Steady count 10 with simultaneous push/pop across pointer wrap.
    fill(10, 8'h00);
    for (int k = 0; k < 50; k++) begin
      step(1'b0, 1'b1, 8'(10 + k), 1'b1);
      chk("steady_count", 32'(count0), 32'd10);
      chk("steady_order", 32'(rdata0), 32'(k));
      check_model();
    end
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // Flush beats a concurrent write.
    fill(32, 8'h40);
    step(1'b0, 1'b1, 8'hEE, 1'b0);
    drain(15);
    chk("pre_flush", {count0, ov0}, {6'd17, 1'b1});
    step(1'b1, 1'b1, 8'h77, 1'b0);
    chk("flush_clear", {count0, empty0, ov0, emptyf}, {6'd0, 1'b1, 1'b0, 1'b1});
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("flush_write_dropped", {count0, empty0}, {6'd0, 1'b1});

    // FWFT: word visible the cycle after its write, before any pop.
    step(1'b0, 1'b1, 8'h5C, 1'b0);
    chk("fwft_visible", {rdataf, emptyf}, {8'h5C, 1'b0});
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("fwft_pop_empty", 32'(emptyf), 32'd1);
    check_model();

    // Asynchronous reset between clock edges.
    fill(20, 8'hC0);
    drain(1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {rdata0, full0, empty0, af0, ae0, count0, ov0, un0},
        {8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0});
    chk("async_rst_fwft", {countf, emptyf}, {6'd0, 1'b1});
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check_model();

    // Random traffic with phases biased toward filling and draining.
    for (int i = 0; i < 3000; i++) begin
      int wp;
      logic f, w, r;
      case ((i / 250) % 4)
        0:       wp = 80;
        1:       wp = 20;
        2:       wp = 95;
        default: wp = 50;
      endcase
      w = ($urandom_range(0, 99) < wp);
      r = ($urandom_range(0, 99) < (100 - wp + 10));
      f = ($urandom_range(0, 299) == 0);
      step(f, w, 8'($urandom), r);
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
